serial_adder_ctrl: RTL and testbench

//   Bit-serial add controller. Accepts two WIDTH-bit operands and a carry-in over a

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/fa_bit_cell.sv | 16 +
 rtl/serial_adder_ctrl.sv | 118 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add controller.
//   ST_IDLE / ST_RUN / ST_DONE : controller state encoding
//   SA_WIDTH                   : default operand/result width
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SA_WIDTH = 8;

endpackage

// File: rtl/fa_bit_cell.sv
// Single full-adder cell, purely combinational.
//   a, b, c : input bits (c is carry-in)
//   s       : sum bit
//   co      : carry-out (majority of a, b, c)
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: accepts a, b, cin over a valid/ready handshake,
// steps one full-adder cell LSB-first for WIDTH cycles, then presents
// {cout, sum} over a second valid/ready handshake.
//   clk, rst_n          : clock, async active-low reset
//   in_valid, in_ready  : operand handshake (ready only in IDLE)
//   a, b, cin           : operands, sampled on accept
//   out_valid, out_ready: result handshake (valid only in DONE)
//   sum, cout           : registered result
//   busy                : high in RUN or DONE
//
// state   | meaning
// --------+---------------------------------------------
// ST_IDLE | waiting for operands, previous result held
// ST_RUN  | one bit per cycle through the full-adder cell
// ST_DONE | result presented until the sink takes it
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s_bit;
    logic             c_next;
    logic             last_bit;

    assign last_bit = (cnt == CNT_LAST);

    fa_bit_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .c  (carry),
        .s  (s_bit),
        .co (c_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last_bit)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state == ST_RUN) || (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    carry <= c_next;
                    sum   <= {s_bit, sum[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    // Hold the counter at the terminal value so it never wraps.
                    if (last_bit) begin
                        cout <= c_next;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;

    logic       rand_mode = 1'b0;
    logic       ready_dir = 1'b1;
    logic       rnd_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int n_sent = 0;
    int n_got  = 0;
    logic [8:0] sb[$];

    assign out_ready = rand_mode ? rnd_ready : ready_dir;

    always #5 clk = ~clk;

    always @(posedge clk) rnd_ready <= 1'($urandom_range(0, 1));

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    // Monitor: a result is consumed on the edge following a negedge where
    // out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [8:0] exp_v;
            n_got++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got {cout,sum}=%h, no result expected", {cout, sum});
            end else begin
                exp_v = sb.pop_front();
                if ({cout, sum} !== exp_v) begin
                    errors++;
                    $display("FAIL result: got {cout,sum}=%h, expected %h", {cout, sum}, exp_v);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp_v);
        end
    endtask

    // Drive operands from posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
        int w;
        a = ta;
        b = tb_v;
        cin = tc;
        in_valid = 1'b1;
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", w);
                break;
            end
        end
        if (in_ready) begin
            sb.push_back({1'b0, ta} + {1'b0, tb_v} + {8'h00, tc});
            n_sent++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || out_valid) && w < 400) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int j;
        logic [8:0] held;

        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic add, latency accept+8
        ready_dir = 1'b1;
        send(8'h5A, 8'h3C, 1'b0);
        j = 0;
        @(negedge clk);
        chk("t1_busy_run", 32'(busy), 32'd1);
        chk("t1_in_ready_run", 32'(in_ready), 32'd0);
        while (!out_valid && j < 20) begin
            @(negedge clk);
            j++;
        end
        chk("t1_latency", 32'(j), 32'd8);
        drain();

        // 2: carry propagation corners
        send(8'hFF, 8'h01, 1'b0);
        drain();
        send(8'hFF, 8'hFF, 1'b1);
        drain();

        // 3: backpressure
        ready_dir = 1'b0;
        send(8'h81, 8'h80, 1'b1);
        j = 0;
        while (!out_valid && j < 20) begin
            @(negedge clk);
            j++;
        end
        chk("t3_valid", 32'(out_valid), 32'd1);
        held = 9'h102;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_result", 32'({cout, sum}), 32'(held));
            chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        ready_dir = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_idle_in_ready", 32'(in_ready), 32'd1);
        chk("t3_idle_out_valid", 32'(out_valid), 32'd0);
        chk("t3_queue", 32'(sb.size()), 32'd0);

        // 4: in_valid during RUN ignored
        send(8'h01, 8'h02, 1'b0);
        a = 8'h11;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_in_ready_run", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        chk("t4_no_extra", 32'(busy), 32'd0);

        // 5: reset mid-RUN
        send(8'hAA, 8'h55, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_sum", 32'(sum), 32'd0);
        chk("t5_cout", 32'(cout), 32'd0);
        sb.delete();
        n_sent--;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        send(8'h01, 8'h01, 1'b0);
        drain();

        // 6: random operands with random gaps and backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();
        rand_mode = 1'b0;
        chk("sent_vs_got", 32'(n_got), 32'(n_sent));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
